// File: rtl/sender_tx_queue.sv
// Transmit byte queue feeding the CDC sender in the clk_s domain.
// A FIFO of DEPTH bytes is drained one transfer at a time, gated by the sender's idle flag.
module sender_tx_queue #(
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter int BUSY_TO = 4
) (
   input  logic          clk_s,
   input  logic          reset_s,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          snd_start,
   output logic [7:0]    snd_data,
   input  logic          snd_ready,
   output logic [AW:0]   level,
   output logic          empty,
   output logic          full,
   output logic          busy,
   output logic [15:0]   xfer_count,
   output logic          to_err
);

   localparam int          LW     = AW + 1;
   localparam logic [3:0]  TO_MAX = 4'(BUSY_TO);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [7:0]     mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]  level_q, level_d;
   logic [7:0]     data_q, data_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [15:0]    xfer_q, xfer_d;
   logic           to_err_q, to_err_d;
   logic           push, pop, load;

   assign empty      = (level_q == '0);
   assign full       = (level_q == LW'(DEPTH));
   assign in_ready   = ~full;
   assign level      = level_q;
   assign busy       = (state_q != S_IDLE);
   assign snd_start  = (state_q == S_LAUNCH);
   assign snd_data   = data_q;
   assign xfer_count = xfer_q;
   assign to_err     = to_err_q;

   // A full queue refuses the push even if this edge also pops.
   assign push = in_valid & ~full;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      to_err_d = to_err_q;
      load     = 1'b0;
      pop      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!empty && snd_ready) begin
               load    = 1'b1;
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (!snd_ready) begin
               state_d = S_WAIT_DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
               // Sender never went busy: retry the same byte.
               if (cnt_d == TO_MAX) begin
                  to_err_d = 1'b1;
                  state_d  = S_IDLE;
               end
            end
         end
         S_WAIT_DONE: begin
            if (snd_ready) begin
               pop     = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      data_d   = data_q;
      xfer_d   = xfer_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         xfer_d   = xfer_q + 16'd1;
      end
      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      if (load) data_d = mem_q[rd_ptr_q];
   end

   always_ff @(posedge clk_s or negedge reset_s) begin
      if (!reset_s) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         data_q   <= '0;
         cnt_q    <= '0;
         xfer_q   <= '0;
         to_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         xfer_q   <= xfer_d;
         to_err_q <= to_err_d;
      end
   end

   always_ff @(posedge clk_s) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

endmodule

// File: tb/tb_sender_tx_queue.sv
// Bench for sender_tx_queue: directed tables and sequences plus random
// traffic checked against a queue-based reference and a behavioural sender.
module tb_sender_tx_queue;

   localparam int DEPTH   = 8;
   localparam int AW      = 3;
   localparam int BUSY_TO = 4;

   logic          clk_s = 1'b0;
   logic          reset_s = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          snd_start;
   logic [7:0]    snd_data;
   logic          snd_ready = 1'b1;
   logic [AW:0]   level;
   logic          empty, full, busy;
   logic [15:0]   xfer_count;
   logic          to_err;

   always #5 clk_s = ~clk_s;

   sender_tx_queue #(.DEPTH(DEPTH), .AW(AW), .BUSY_TO(BUSY_TO)) dut (
      .clk_s      (clk_s),
      .reset_s    (reset_s),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .snd_start  (snd_start),
      .snd_data   (snd_data),
      .snd_ready  (snd_ready),
      .level      (level),
      .empty      (empty),
      .full       (full),
      .busy       (busy),
      .xfer_count (xfer_count),
      .to_err     (to_err)
   );

   int            n_chk = 0;
   int            n_pass = 0;
   byte unsigned  mq[$];
   logic [15:0]   mx = 16'd0;
   bit            exp_toerr = 1'b0;
   bit            toerr_dc = 1'b0;
   bit            pop_pending = 1'b0;
   bit            saw_start = 1'b0;
   bit            prev_start = 1'b0;
   bit            sender_en = 1'b0;
   int            phase = 0;
   int            cnt = 0;
   int            d_lo = 0, d_hi = 0, b_lo = 1, b_hi = 1;
   logic [7:0]    last_start_data = 8'h00;
   int            n_starts = 0;

   typedef struct {
      bit           v;
      byte unsigned d;
      int           lvl;
      bit           fl;
      bit           rdy;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Sender: stays idle d cycles after start, then busy b cycles.
   task automatic sender_step();
      pop_pending = 1'b0;
      if (!sender_en) return;
      case (phase)
         0: begin
            snd_ready = 1'b1;
            if (saw_start) begin
               phase = 1;
               cnt = $urandom_range(d_hi, d_lo);
            end
         end
         1: begin
            if (cnt > 0) begin
               cnt--;
               snd_ready = 1'b1;
            end else begin
               snd_ready = 1'b0;
               phase = 2;
               cnt = $urandom_range(b_hi, b_lo) - 1;
            end
         end
         default: begin
            if (cnt > 0) cnt--;
            else begin
               snd_ready = 1'b1;
               pop_pending = 1'b1;
               phase = 0;
            end
         end
      endcase
   endtask

   task automatic tick();
      bit push, pop;
      push = in_valid && (mq.size() < DEPTH);
      pop = pop_pending;
      @(posedge clk_s);
      if (pop && mq.size() > 0) begin
         void'(mq.pop_front());
         mx++;
      end
      if (push) mq.push_back(in_data);
      @(negedge clk_s);
      chk("level", int'(level), mq.size());
      chk("empty", int'(empty), int'(mq.size() == 0));
      chk("full", int'(full), int'(mq.size() == DEPTH));
      chk("in_ready", int'(in_ready), int'(mq.size() < DEPTH));
      chk("xfer_count", int'(xfer_count), int'(mx));
      if (!toerr_dc) chk("to_err", int'(to_err), int'(exp_toerr));
      saw_start = snd_start;
      if (snd_start) begin
         chk("start_spacing", int'(prev_start), 0);
         chk("start_has_data", int'(mq.size() != 0), 1);
         if (mq.size() != 0) chk("snd_data", int'(snd_data), int'(mq[0]));
         last_start_data = snd_data;
         n_starts++;
      end
      prev_start = snd_start;
      sender_step();
   endtask

   task automatic wait_idle();
      int k = 0;
      in_valid = 1'b0;
      while ((mq.size() != 0 || phase != 0) && k < 3000) begin
         tick();
         k++;
      end
      chk("drain_in_time", int'(k < 3000), 1);
   endtask

   task automatic push_byte(input byte unsigned b);
      bit acc = 1'b0;
      int k = 0;
      in_data = b;
      in_valid = 1'b1;
      while (!acc && k < 200) begin
         acc = (mq.size() < DEPTH);
         tick();
         k++;
      end
      in_valid = 1'b0;
      chk("push_accepted", int'(acc), 1);
   endtask

   task automatic do_reset();
      reset_s = 1'b0;
      #2;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_snd_start", int'(snd_start), 0);
      chk("rst_snd_data", int'(snd_data), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_xfer", int'(xfer_count), 0);
      chk("rst_to_err", int'(to_err), 0);
      mq.delete();
      mx = 16'd0;
      phase = 0;
      pop_pending = 1'b0;
      saw_start = 1'b0;
      prev_start = 1'b0;
      exp_toerr = 1'b0;
      toerr_dc = 1'b0;
      repeat (2) @(negedge clk_s);
      reset_s = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int s0, k;
      for (int i = 0; i < 9; i++) begin
         tbl[i].v = 1'b1;
         tbl[i].d = byte'(i + 1);
         tbl[i].lvl = (i + 1 > DEPTH) ? DEPTH : i + 1;
         tbl[i].fl = (i >= DEPTH - 1);
         tbl[i].rdy = (i < DEPTH - 1);
      end
      tbl[9] = '{1'b0, 8'h00, DEPTH, 1'b1, 1'b0};

      do_reset();

      // Single byte with latency check.
      sender_en = 1'b1;
      d_lo = 0; d_hi = 0; b_lo = 6; b_hi = 6;
      s0 = n_starts;
      in_data = 8'hA5;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("lat_no_start_yet", int'(snd_start), 0);
      chk("lat_busy_idle", int'(busy), 0);
      tick();
      chk("lat_start", int'(snd_start), 1);
      chk("lat_data", int'(snd_data), 8'hA5);
      chk("lat_busy", int'(busy), 1);
      wait_idle();
      chk("single_starts", n_starts - s0, 1);
      chk("single_data_held", int'(snd_data), 8'hA5);
      chk("single_xfer", int'(xfer_count), 1);
      chk("single_busy_done", int'(busy), 0);

      // Fill to full with sender held busy, ninth byte refused.
      sender_en = 1'b0;
      snd_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_valid = tbl[i].v;
         in_data = tbl[i].d;
         tick();
         chk("tbl_level", int'(level), tbl[i].lvl);
         chk("tbl_full", int'(full), int'(tbl[i].fl));
         chk("tbl_in_ready", int'(in_ready), int'(tbl[i].rdy));
      end
      in_valid = 1'b0;
      s0 = n_starts;
      snd_ready = 1'b1;
      sender_en = 1'b1;
      d_lo = 0; d_hi = 2; b_lo = 1; b_hi = 4;
      wait_idle();
      chk("fill_starts", n_starts - s0, 8);
      chk("fill_last", int'(last_start_data), 8'h08);
      chk("fill_xfer", int'(xfer_count), 9);

      // Continuous traffic across pointer wrap.
      for (int i = 0; i < 20; i++) push_byte(byte'(8'h10 + i));
      wait_idle();
      chk("wrap_level", int'(level), 0);
      chk("wrap_last", int'(last_start_data), 8'h23);
      chk("wrap_xfer", int'(xfer_count), 29);

      // Sender never goes busy: timeout, then retry the same byte.
      sender_en = 1'b0;
      snd_ready = 1'b1;
      toerr_dc = 1'b1;
      s0 = n_starts;
      in_data = 8'h3C;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      k = 0;
      while (n_starts - s0 < 2 && k < 40) begin
         tick();
         k++;
      end
      chk("retry_starts", n_starts - s0, 2);
      chk("retry_to_err", int'(to_err), 1);
      chk("retry_level", int'(level), 1);
      chk("retry_data", int'(snd_data), 8'h3C);
      toerr_dc = 1'b0;
      exp_toerr = 1'b1;
      sender_en = 1'b1;
      d_lo = 0; d_hi = 0; b_lo = 2; b_hi = 2;
      sender_step();
      wait_idle();
      chk("retry_xfer", int'(xfer_count), 30);

      // Push on the same edge as a pop with three queued.
      sender_en = 1'b0;
      snd_ready = 1'b0;
      push_byte(8'h61);
      push_byte(8'h62);
      push_byte(8'h63);
      sender_en = 1'b1;
      snd_ready = 1'b1;
      k = 0;
      while (!pop_pending && k < 50) begin
         tick();
         k++;
      end
      chk("simul_pre_level", int'(level), 3);
      in_data = 8'h77;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("simul_level", int'(level), 3);
      wait_idle();
      chk("simul_last", int'(last_start_data), 8'h77);
      chk("simul_xfer", int'(xfer_count), 34);

      // Reset while the sender is busy with four bytes queued.
      sender_en = 1'b0;
      snd_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_byte(byte'(8'h81 + i));
      sender_en = 1'b1;
      snd_ready = 1'b1;
      d_lo = 0; d_hi = 0; b_lo = 4; b_hi = 4;
      k = 0;
      while (phase != 2 && k < 50) begin
         tick();
         k++;
      end
      chk("mid_reach_busy", phase, 2);
      tick();
      chk("mid_busy", int'(busy), 1);
      do_reset();
      snd_ready = 1'b1;
      s0 = n_starts;
      repeat (10) tick();
      chk("post_rst_starts", n_starts - s0, 0);
      push_byte(8'h5A);
      wait_idle();
      chk("post_rst_xfer", int'(xfer_count), 1);
      chk("post_rst_data", int'(last_start_data), 8'h5A);

      // Random traffic against the reference queue.
      d_lo = 0; d_hi = 2; b_lo = 1; b_hi = 4;
      for (int i = 0; i < 400; i++) begin
         in_valid = 1'($urandom_range(1, 0));
         in_data = 8'($urandom);
         tick();
      end
      wait_idle();
      chk("rand_level", int'(level), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
